dest_track_pipe: RTL and testbench
==================================

Name: dest_track_pipe

Overview:
- Pipeline destination tracker and load-use hazard unit. It sits directly upstream of the forwarding unit.
- Carries each instruction's destination register and control bits through the ID/EX, EX/MEM and MEM/WB stages.
- Drives the em_rd/mw_rd addresses and their write-valid bits that the forwarding unit compares against RS/RT.
- Detects load-use hazards, stalls decode and inserts bubbles. Honours a global memory-wait freeze.

Parameters:
- REG_ADDR_W, 4, register address width (16-entry register file).
- LOAD_STALL, 1, bubble cycles inserted per load-use hazard (legal range 1..3).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  decode stage holds a real instruction.
- id_rs  input  REG_ADDR_W  decode source register A.
- id_rt  input  REG_ADDR_W  decode source register B.
- id_rd  input  REG_ADDR_W  decode destination register.
- id_reg_write  input  1  decoded instruction writes the register file.
- id_mem_read  input  1  decoded instruction is a load.
- mem_wait  input  1  data memory busy; freezes all stage registers.
- ex_rd  output  REG_ADDR_W  ID/EX destination.
- ex_reg_write  output  1  ID/EX write-valid.
- em_rd  output  REG_ADDR_W  EX/MEM destination (forwarding EMRD).
- em_reg_write  output  1  EX/MEM write-valid.
- mw_rd  output  REG_ADDR_W  MEM/WB destination (forwarding MWRD).
- mw_reg_write  output  1  MEM/WB write-valid.
- stall  output  1  hold PC and IF/ID this cycle.
- bubble_cnt  output  2  remaining load-use bubble cycles.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - All *_rd outputs = 0; all *_reg_write outputs = 0.
  - Internal ex_mem_read = 0; bubble_cnt = 0; state = RUN; stall = 0.
  - rst has priority over mem_wait and all other inputs. Reset mid-hazard discards the pending bubbles.
- Stage advance, each edge while not frozen:
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX.
  - ID/EX <= decode fields, or a bubble (rd=0, reg_write=0, mem_read=0) when stall is asserted or id_valid=0.
  - Destination registers carry no latency beyond one cycle per stage. An instruction accepted at edge N shows on ex_rd after N, em_rd after N+1, mw_rd after N+2.
- Hazard detect (combinational from current state):
  - hit = ex_mem_read & ex_reg_write & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
- State machine:
  - RUN:
    - stall = hit.
    - On hit with mem_wait=0: insert a bubble into ID/EX. bubble_cnt <= LOAD_STALL-1. If LOAD_STALL>1, go to HOLD; else stay in RUN.
  - HOLD:
    - stall = 1; a bubble is inserted each cycle.
    - bubble_cnt decrements by 1 per unfrozen edge.
    - When bubble_cnt==0 at the edge, return to RUN; the decode instruction is accepted on the following edge.
  - A freeze is not a transition: state and bubble_cnt hold while mem_wait=1.
- mem_wait:
  - mem_wait=1 freezes ID/EX, EX/MEM, MEM/WB, state and bubble_cnt.
  - stall = 1 while mem_wait=1, regardless of state.
  - Outputs hold their values throughout the freeze.
- Simultaneous events:
  - hit and mem_wait together: freeze wins; the hazard is re-evaluated once mem_wait drops.
  - id_valid=0 during HOLD: the count still decrements.
- Width rules:
  - Address compares are full REG_ADDR_W equality.
  - bubble_cnt saturates at 0 and never wraps.

Optional Feature:
- Macro: DEST_TRACK_R0_HARDWIRED_EN.
- Defined:
  - Register 0 is hardwired zero. id_rd==0 forces the ID/EX reg_write to 0, so em_reg_write and mw_reg_write never assert for rd 0.
  - The hazard compare ignores id_rs/id_rt==0; a load to r0 never stalls.
- Undefined: r0 is an ordinary register and is tracked and compared like any other.

Test Plan:
- Reset then stream, LOAD_STALL=1. Reset, then issue id_rd=C,reg_write=1 / id_rd=D,reg_write=1 / id_rd=0,reg_write=0 on consecutive edges.
  - Required: em_rd=C while mw_rd=0; next cycle em_rd=D, mw_rd=C; no stall asserted.
- Load-use, LOAD_STALL=1. Load to rd=8, followed by id_rs=9, id_rt=8.
  - Required: stall=1 for exactly one cycle; ex_reg_write=0 (bubble) that cycle; the dependent instruction enters ID/EX on the next edge.
- Multi-bubble, LOAD_STALL=3. Load rd=F, next id_rs=F.
  - Required: stall=1 for 3 cycles; bubble_cnt sequence 2,1,0; three bubbles are observed on em_reg_write=0.
- Memory freeze mid-hazard, LOAD_STALL=3. Assert mem_wait for 4 cycles after the first bubble.
  - Required: bubble_cnt holds at 2 and em_rd/mw_rd hold their values throughout; stall stays 1; the count resumes 2→1→0 after release.
- Reset during HOLD. Assert rst while bubble_cnt=1.
  - Required: next cycle stall=0, bubble_cnt=0, all rd outputs 0, all reg_write outputs 0.
- R0 feature, with DEST_TRACK_R0_HARDWIRED_EN defined. Load rd=0, next id_rs=0.
  - Required: stall=0; em_reg_write=0 when the load reaches EX/MEM.
  - Without the macro: stall=1 for one cycle, and em_reg_write=1 with em_rd=0.

Source files
------------

// File: rtl/dest_track_pipe.sv
// Destination tracker and load-use hazard unit feeding the forwarding unit.
// Optional build macro: DEST_TRACK_R0_HARDWIRED_EN (register 0 hardwired to zero).
module dest_track_pipe #(
   parameter int REG_ADDR_W = 4,
   parameter int LOAD_STALL = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  mem_wait,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_reg_write,
   output logic [REG_ADDR_W-1:0] em_rd,
   output logic                  em_reg_write,
   output logic [REG_ADDR_W-1:0] mw_rd,
   output logic                  mw_reg_write,
   output logic                  stall,
   output logic [1:0]            bubble_cnt
);

   typedef enum logic {RUN, HOLD} state_t;

   localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL - 1);

   state_t                  state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d, em_rd_q, em_rd_d, mw_rd_q, mw_rd_d;
   logic                    ex_rw_q, ex_rw_d, em_rw_q, em_rw_d, mw_rw_q, mw_rw_d;
   logic                    ex_mr_q, ex_mr_d;
   logic                    rs_match, rt_match, id_rw_eff, hit, insert_bubble;

   always_comb begin
`ifdef DEST_TRACK_R0_HARDWIRED_EN
      rs_match  = (ex_rd_q == id_rs) && (id_rs != '0);
      rt_match  = (ex_rd_q == id_rt) && (id_rt != '0);
      id_rw_eff = id_reg_write && (id_rd != '0);
`else
      rs_match  = (ex_rd_q == id_rs);
      rt_match  = (ex_rd_q == id_rt);
      id_rw_eff = id_reg_write;
`endif
      hit = ex_mr_q & ex_rw_q & id_valid & (rs_match | rt_match);
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ex_rd_d       = ex_rd_q;
      ex_rw_d       = ex_rw_q;
      ex_mr_d       = ex_mr_q;
      em_rd_d       = em_rd_q;
      em_rw_d       = em_rw_q;
      mw_rd_d       = mw_rd_q;
      mw_rw_d       = mw_rw_q;
      insert_bubble = 1'b0;
      stall         = 1'b1;
      // A memory wait freezes every register, so only the unfrozen path advances
      if (!mem_wait) begin
         case (state_q)
            RUN: begin
               stall = hit;
               if (hit) begin
                  insert_bubble = 1'b1;
                  cnt_d         = CNT_INIT;
                  state_d       = (LOAD_STALL > 1) ? HOLD : RUN;
               end
            end
            HOLD: begin
               stall         = 1'b1;
               insert_bubble = 1'b1;
               // Leaving HOLD as the count reaches zero gives LOAD_STALL bubbles in total
               if (cnt_q <= 2'd1) begin
                  cnt_d   = 2'd0;
                  state_d = RUN;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            default: begin
               stall   = 1'b0;
               state_d = RUN;
            end
         endcase
         mw_rd_d = em_rd_q;
         mw_rw_d = em_rw_q;
         em_rd_d = ex_rd_q;
         em_rw_d = ex_rw_q;
         if (insert_bubble || !id_valid) begin
            ex_rd_d = '0;
            ex_rw_d = 1'b0;
            ex_mr_d = 1'b0;
         end else begin
            ex_rd_d = id_rd;
            ex_rw_d = id_rw_eff;
            ex_mr_d = id_mem_read;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
         ex_rd_q <= '0;
         ex_rw_q <= 1'b0;
         ex_mr_q <= 1'b0;
         em_rd_q <= '0;
         em_rw_q <= 1'b0;
         mw_rd_q <= '0;
         mw_rw_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ex_rd_q <= ex_rd_d;
         ex_rw_q <= ex_rw_d;
         ex_mr_q <= ex_mr_d;
         em_rd_q <= em_rd_d;
         em_rw_q <= em_rw_d;
         mw_rd_q <= mw_rd_d;
         mw_rw_q <= mw_rw_d;
      end
   end

   assign ex_rd        = ex_rd_q;
   assign ex_reg_write = ex_rw_q;
   assign em_rd        = em_rd_q;
   assign em_reg_write = em_rw_q;
   assign mw_rd        = mw_rd_q;
   assign mw_reg_write = mw_rw_q;
   assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_dest_track_pipe.sv
// Bench for dest_track_pipe: vector tables on LOAD_STALL=1 and LOAD_STALL=3 instances,
// plus a scoreboarded stream of hazard-free instructions.
module tb_dest_track_pipe;

`ifdef DEST_TRACK_R0_HARDWIRED_EN
   localparam bit R0 = 1'b1;
`else
   localparam bit R0 = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, id_valid, id_reg_write, id_mem_read, mem_wait;
   logic [3:0] id_rs, id_rt, id_rd;

   logic [3:0] a_ex_rd, a_em_rd, a_mw_rd, b_ex_rd, b_em_rd, b_mw_rd;
   logic       a_ex_rw, a_em_rw, a_mw_rw, a_stall, b_ex_rw, b_em_rw, b_mw_rw, b_stall;
   logic [1:0] a_cnt, b_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dest_track_pipe #(.REG_ADDR_W(4), .LOAD_STALL(1)) u1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .mem_wait(mem_wait), .ex_rd(a_ex_rd), .ex_reg_write(a_ex_rw), .em_rd(a_em_rd),
      .em_reg_write(a_em_rw), .mw_rd(a_mw_rd), .mw_reg_write(a_mw_rw),
      .stall(a_stall), .bubble_cnt(a_cnt));

   dest_track_pipe #(.REG_ADDR_W(4), .LOAD_STALL(3)) u3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .mem_wait(mem_wait), .ex_rd(b_ex_rd), .ex_reg_write(b_ex_rw), .em_rd(b_em_rd),
      .em_reg_write(b_em_rw), .mw_rd(b_mw_rd), .mw_reg_write(b_mw_rw),
      .stall(b_stall), .bubble_cnt(b_cnt));

   typedef struct {
      bit sel; bit rst; bit vld;
      logic [3:0] rs, rt, rd;
      bit rw, mr, mw, cs, stall;
      logic [3:0] ex_rd; bit ex_rw;
      logic [3:0] em_rd; bit em_rw;
      logic [3:0] mw_rd; bit mw_rw;
      int cnt;
   } vec_t;

   typedef struct { logic [3:0] rd; bit rw; } sb_t;

   vec_t tbl[$];
   sb_t  sbq[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input bit sel, input bit r, input bit vld, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [3:0] rd, input bit rw, input bit mr,
                      input bit mw, input bit cs, input bit st, input logic [3:0] exd,
                      input bit exw, input logic [3:0] emd, input bit emw,
                      input logic [3:0] mwd, input bit mww, input int cnt);
      vec_t v;
      v.sel = sel; v.rst = r; v.vld = vld; v.rs = rs; v.rt = rt; v.rd = rd;
      v.rw = rw; v.mr = mr; v.mw = mw; v.cs = cs; v.stall = st;
      v.ex_rd = exd; v.ex_rw = exw; v.em_rd = emd; v.em_rw = emw;
      v.mw_rd = mwd; v.mw_rw = mww; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic rst_vec(input bit sel);
      add(sel, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_reg_write = 0; id_mem_read = 0; mem_wait = 0;

      // Stream C, D, nop on LOAD_STALL=1
      rst_vec(0);
      add(0, 0, 1, 1, 2, 4'hC, 1, 0, 0, 1, 0, 4'hC, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 1, 2, 4'hD, 1, 0, 0, 1, 0, 4'hD, 1, 4'hC, 1, 0, 0, 0);
      add(0, 0, 1, 1, 2, 4'h0, 0, 0, 0, 1, 0, 4'h0, 0, 4'hD, 1, 4'hC, 1, 0);
      // Load-use, LOAD_STALL=1
      rst_vec(0);
      add(0, 0, 1, 0, 0, 8, 1, 1, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 9, 8, 5, 1, 0, 0, 1, 1, 0, 0, 8, 1, 0, 0, 0);
      add(0, 0, 1, 9, 8, 5, 1, 0, 0, 1, 0, 5, 1, 0, 0, 8, 1, 0);
      add(0, 0, 0, 9, 8, 5, 1, 0, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0);
      // Multi-bubble, LOAD_STALL=3
      rst_vec(1);
      add(1, 0, 1, 1, 1, 4'hF, 1, 1, 0, 1, 0, 4'hF, 1, 0, 0, 0, 0, 0);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 1, 0, 0, 4'hF, 1, 0, 0, 2);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 4'hF, 1, 1);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 4'hF, 1, 2, 1, 0, 0, 1, 0, 0, 0, 2, 1, 0, 0, 0);
      // Freeze after the first bubble, LOAD_STALL=3
      rst_vec(1);
      add(1, 0, 1, 1, 1, 4'hF, 1, 1, 0, 1, 0, 4'hF, 1, 0, 0, 0, 0, 0);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 1, 0, 0, 4'hF, 1, 0, 0, 2);
      for (int k = 0; k < 4; k++)
         add(1, 0, 1, 4'hF, 1, 2, 1, 0, 1, 1, 1, 0, 0, 4'hF, 1, 0, 0, 2);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 4'hF, 1, 1);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0);
      // Reset while HOLD has bubble_cnt=1
      rst_vec(1);
      add(1, 0, 1, 1, 1, 4'hF, 1, 1, 0, 1, 0, 4'hF, 1, 0, 0, 0, 0, 0);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 1, 0, 0, 4'hF, 1, 0, 0, 2);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 4'hF, 1, 1);
      add(1, 1, 1, 4'hF, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 1, 4'hF, 1, 2, 1, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0);
      // Load to r0 followed by a use of r0, LOAD_STALL=1
      rst_vec(0);
      add(0, 0, 1, 3, 3, 0, 1, 1, 0, 1, 0, 0, !R0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 4, 6, 1, 0, 0, 1, !R0, R0 ? 4'd6 : 4'd0, R0, 0, !R0, 0, 0, 0);
      add(0, 0, 0, 0, 4, 6, 1, 0, 0, 1, 0, 0, 0, R0 ? 4'd6 : 4'd0, R0, 0, !R0, 0);

      @(posedge clk); #1;
      for (int i = 0; i < tbl.size(); i++) begin
         logic [3:0] exd, emd, mwd;
         logic       exw, emw, mww, st;
         int         cnt;
         rst = tbl[i].rst; id_valid = tbl[i].vld; id_rs = tbl[i].rs; id_rt = tbl[i].rt;
         id_rd = tbl[i].rd; id_reg_write = tbl[i].rw; id_mem_read = tbl[i].mr;
         mem_wait = tbl[i].mw;
         #2;
         st = tbl[i].sel ? b_stall : a_stall;
         if (tbl[i].cs) chk($sformatf("v%0d stall", i), st, tbl[i].stall);
         @(posedge clk); #1;
         exd = tbl[i].sel ? b_ex_rd : a_ex_rd;  exw = tbl[i].sel ? b_ex_rw : a_ex_rw;
         emd = tbl[i].sel ? b_em_rd : a_em_rd;  emw = tbl[i].sel ? b_em_rw : a_em_rw;
         mwd = tbl[i].sel ? b_mw_rd : a_mw_rd;  mww = tbl[i].sel ? b_mw_rw : a_mw_rw;
         cnt = tbl[i].sel ? int'(b_cnt) : int'(a_cnt);
         chk($sformatf("v%0d ex_rd", i), exd, tbl[i].ex_rd);
         chk($sformatf("v%0d ex_reg_write", i), exw, tbl[i].ex_rw);
         chk($sformatf("v%0d em_rd", i), emd, tbl[i].em_rd);
         chk($sformatf("v%0d em_reg_write", i), emw, tbl[i].em_rw);
         chk($sformatf("v%0d mw_rd", i), mwd, tbl[i].mw_rd);
         chk($sformatf("v%0d mw_reg_write", i), mww, tbl[i].mw_rw);
         chk($sformatf("v%0d bubble_cnt", i), cnt, tbl[i].cnt);
      end

      // Hazard-free random stream, scoreboarded at the EX/MEM stage
      rst = 1'b1; id_valid = 0; id_mem_read = 0; mem_wait = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         sb_t e;
         id_valid     = 1'($urandom_range(0, 3) != 0);
         id_rs        = 4'($urandom);
         id_rt        = 4'($urandom);
         id_rd        = 4'($urandom);
         id_reg_write = 1'($urandom);
         id_mem_read  = 1'b0;
         e.rd = id_valid ? id_rd : 4'd0;
         e.rw = id_valid && id_reg_write && !(R0 && id_rd == 4'd0);
         sbq.push_back(e);
         #2;
         chk($sformatf("s%0d stall", i), a_stall, 0);
         @(posedge clk); #1;
         if (sbq.size() == 2) begin
            e = sbq.pop_front();
            chk($sformatf("s%0d em_rd", i), a_em_rd, e.rd);
            chk($sformatf("s%0d em_reg_write", i), a_em_rw, e.rw);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
